pixel_rx_sequencer: RTL and testbench
=====================================

// Module: pixel_rx_sequencer
// PURPOSE
//  Upstream controller for the RGB pixel bank. Consumes the UART receiver's byte stream
//  (rx_ready pulse + rx_data) and steers each byte into the R, G or B register via
//  one-cycle load strobes r0/r1/r2, in the fixed order R->G->B.
//  After each complete triplet it flags pixel_valid with a frame address for the frame
//  store. A wrapping address counter marks the end of each frame; an optional inter-byte
//  timeout re-synchronises to R.
// PARAMETERS
//  NUM_PIXELS      4096       pixels per frame; pixel_addr wraps after NUM_PIXELS-1
//  TIMEOUT_CYCLES  1_000_000  max idle clocks between bytes of one pixel (used only with PIXEL_SEQ_TIMEOUT_EN)
//  localparam ADDR_W = $clog2(NUM_PIXELS)
// PORTS
//  clk            in   1       system clock
//  reset          in   1       asynchronous reset, active-low
//  rx_ready       in   1       one-cycle pulse: rx_data holds a new byte this cycle
//  rx_data        in   8       received byte (valid only while rx_ready=1)
//  frame_restart  in   1       synchronous restart: state->WAIT_R, pixel_addr->0
//  r0             out  1       load strobe, R register (combinational)
//  r1             out  1       load strobe, G register (combinational)
//  r2             out  1       load strobe, B register (combinational)
//  pixel_valid    out  1       one-cycle pulse: bank output holds a complete pixel
//  pixel_addr     out  ADDR_W  frame address of the pixel flagged by pixel_valid
//  frame_done     out  1       pulses together with pixel_valid when pixel_addr==NUM_PIXELS-1
//  sync_err       out  1       one-cycle pulse on timeout resync (0 when feature compiled out)
// BEHAVIOUR
//  Reset (reset=0, async): state=WAIT_R, pixel_addr=0, timeout counter=0.
//   pixel_valid, frame_done and sync_err are 0; r0/r1/r2 are 0 because rx_ready is ignored.
//  States: WAIT_R, WAIT_G, WAIT_B, COMMIT (registered FSM).
//  Strobes are combinational, so the bank captures rx_data on the same edge:
//   r0 = rx_ready & (state==WAIT_R | state==COMMIT); r1 = rx_ready & state==WAIT_G;
//   r2 = rx_ready & state==WAIT_B. At most one strobe is high in any cycle.
//  Transitions:
//   WAIT_R -rx_ready-> WAIT_G; WAIT_G -rx_ready-> WAIT_B; WAIT_B -rx_ready-> COMMIT.
//   COMMIT lasts exactly one cycle:
//    - pixel_valid=1; pixel_addr shows the current address.
//    - frame_done=1 when pixel_addr==NUM_PIXELS-1.
//    - Next edge: pixel_addr increments, wrapping NUM_PIXELS-1 -> 0.
//   COMMIT with rx_ready=1: the byte is taken as R (r0=1) and the next state is WAIT_G.
//   COMMIT with rx_ready=0: the next state is WAIT_R.
//  Latency: pixel_valid is asserted one cycle after the B-byte rx_ready cycle, which is when
//   the bank holds {R,G,B}.
//  pixel_valid and pixel_addr are registered outputs decoded from state.
//  frame_restart=1 overrides everything except async reset:
//   - next state WAIT_R; pixel_addr=0; timeout counter=0.
//   - Strobes stay combinational and may still fire in that cycle, but the FSM does not advance.
//  A partially received pixel (in WAIT_G/WAIT_B) at reset or restart is discarded; bank
//   contents are left untouched.
// CONFIGURATION
//  `define PIXEL_SEQ_TIMEOUT_EN (defined):
//   - Counter width $clog2(TIMEOUT_CYCLES); cleared on every rx_ready and in WAIT_R/COMMIT.
//   - Counts while in WAIT_G or WAIT_B.
//   - When it reaches TIMEOUT_CYCLES-1 with rx_ready=0: next state WAIT_R, sync_err=1 for
//     one cycle, pixel_addr unchanged.
//   - If rx_ready=1 in the expiry cycle, the byte wins: normal transition, no sync_err.
//  PIXEL_SEQ_TIMEOUT_EN undefined: no counter logic; sync_err tied to 0; the FSM waits
//   indefinitely.
// TESTING
//  1. Bytes 0x12,0x34,0x56, 10 idle clk apart -> r0,r1,r2 each high 1 cycle with the matching
//     byte; pixel_valid 1 cycle after the B byte with pixel_addr=0; bank pixel=0x123456.
//  2. NUM_PIXELS=4, 4 triplets -> pixel_addr 0,1,2,3; frame_done only with addr 3;
//     5th triplet reports addr 0.
//  3. R byte in the COMMIT cycle (back-to-back) -> pixel_valid=1 and r0=1 in the same cycle;
//     next state WAIT_G; the following pixel completes correctly.
//  4. Reset (reset=0) after the G byte -> all outputs 0 immediately; after release,
//     0xAA,0xBB,0xCC -> pixel_valid with addr 0 and pixel 0xAABBCC.
//  5. TIMEOUT_EN, TIMEOUT_CYCLES=16:
//     - R byte, then 16 idle clk -> sync_err pulse, state WAIT_R; next byte raises r0.
//     - Same test with a byte exactly in the expiry cycle -> r1, no sync_err.
//  6. frame_restart pulse at pixel_addr=2 in WAIT_B -> next pixel_valid reports addr 0
//     after a full R,G,B triplet.

Source files
------------

// File: rtl/pixel_rx_sequencer.sv
// pixel_rx_sequencer: steers the UART byte stream into the R/G/B bank registers
// through one-cycle load strobes, then flags each complete pixel with its frame
// address. Frame end is marked by the wrapping address counter.
//
// Optional feature macro: PIXEL_SEQ_TIMEOUT_EN
//   defined   - inter-byte timeout counter; a stalled partial pixel is dropped,
//               the sequencer re-synchronises to R and pulses sync_err.
//   undefined - no timeout logic; sync_err is tied low and the FSM waits forever.
module pixel_rx_sequencer #(
    parameter int NUM_PIXELS     = 4096,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int DATA_W         = 8,
    localparam int ADDR_W        = $clog2(NUM_PIXELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              frame_restart,
    output logic              r0,
    output logic              r1,
    output logic              r2,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              frame_done,
    output logic              sync_err
);

    typedef enum logic [1:0] {
        WAIT_R = 2'd0,
        WAIT_G = 2'd1,
        WAIT_B = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              timeout_hit;
    logic              in_partial;

    // The byte itself goes straight from the receiver to the bank registers;
    // this block only decides which register captures it.
    logic unused_rx_data;
    assign unused_rx_data = ^rx_data;

    // A pixel is partially received while waiting for its G or B byte.
    assign in_partial = (state == WAIT_G) || (state == WAIT_B);

`ifdef PIXEL_SEQ_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             sync_err_q;

    // Expiry only counts when no byte arrives in the same cycle: a late byte wins.
    assign timeout_hit = in_partial && !rx_ready && (tmo_cnt == TMO_LAST);

    // Idle-cycle counter, running only while a pixel is partially received.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (frame_restart || rx_ready || !in_partial || timeout_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // sync_err is a registered pulse in the first WAIT_R cycle after a resync.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= timeout_hit && !frame_restart;
        end
    end

    assign sync_err = sync_err_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign sync_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_R;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: restart beats timeout, timeout beats idle waiting.
    always_comb begin
        state_nxt = state;
        if (frame_restart) begin
            state_nxt = WAIT_R;
        end else if (timeout_hit) begin
            state_nxt = WAIT_R;
        end else begin
            case (state)
                WAIT_R: if (rx_ready) state_nxt = WAIT_G;
                WAIT_G: if (rx_ready) state_nxt = WAIT_B;
                WAIT_B: if (rx_ready) state_nxt = COMMIT;
                COMMIT: state_nxt = rx_ready ? WAIT_G : WAIT_R;
                default: state_nxt = WAIT_R;
            endcase
        end
    end

    // Frame address: advances after every COMMIT, wraps at the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (frame_restart) begin
            addr_q <= '0;
        end else if (state == COMMIT) begin
            addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // Load strobes are combinational so the bank captures rx_data on this edge;
    // COMMIT accepts a back-to-back R byte. Strobes are masked during reset.
    always_comb begin
        r0 = reset && rx_ready && ((state == WAIT_R) || (state == COMMIT));
        r1 = reset && rx_ready && (state == WAIT_G);
        r2 = reset && rx_ready && (state == WAIT_B);
    end

    // Pixel flags decode the registered state and address.
    always_comb begin
        pixel_valid = (state == COMMIT);
        pixel_addr  = addr_q;
        frame_done  = (state == COMMIT) && (addr_q == ADDR_LAST);
    end

endmodule

// File: tb/tb_pixel_rx_sequencer.sv
// Testbench for pixel_rx_sequencer: directed scenarios plus a randomized byte
// stream checked against a byte-counting reference model and a model RGB bank.
module tb_pixel_rx_sequencer;

    localparam int NP = 4;
    localparam int TC = 16;
    localparam int AW = $clog2(NP);
`ifdef PIXEL_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_ready;
    logic [7:0]    rx_data;
    logic          frame_restart;
    logic          r0, r1, r2;
    logic          pixel_valid;
    logic [AW-1:0] pixel_addr;
    logic          frame_done;
    logic          sync_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pixel_rx_sequencer #(
        .NUM_PIXELS    (NP),
        .TIMEOUT_CYCLES(TC),
        .DATA_W        (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .frame_restart(frame_restart),
        .r0           (r0),
        .r1           (r1),
        .r2           (r2),
        .pixel_valid  (pixel_valid),
        .pixel_addr   (pixel_addr),
        .frame_done   (frame_done),
        .sync_err     (sync_err)
    );

    // RGB bank driven by the strobes, as the real pixel bank would be.
    logic [23:0] bank;
    always @(posedge clk) begin
        if (r0) bank[23:16] <= rx_data;
        if (r1) bank[15:8]  <= rx_data;
        if (r2) bank[7:0]   <= rx_data;
    end

    // Reference model: counts bytes of the current pixel, remembers a pending
    // completed pixel for one cycle, and counts idle cycles of a partial pixel.
    int          m_n;
    int          m_addr;
    int          m_idle;
    bit          m_pend;
    bit          m_serr;
    logic [7:0]  m_b0, m_b1;
    logic [23:0] m_pix;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_n <= 0; m_addr <= 0; m_idle <= 0; m_pend <= 1'b0; m_serr <= 1'b0;
        end else if (frame_restart) begin
            m_n <= 0; m_addr <= 0; m_idle <= 0; m_pend <= 1'b0; m_serr <= 1'b0;
        end else begin
            m_serr <= 1'b0;
            if (m_pend) begin
                m_pend <= 1'b0;
                m_addr <= (m_addr + 1) % NP;
            end
            if (rx_ready) begin
                m_idle <= 0;
                if (m_n == 0) begin
                    m_b0 <= rx_data; m_n <= 1;
                end else if (m_n == 1) begin
                    m_b1 <= rx_data; m_n <= 2;
                end else begin
                    m_pix <= {m_b0, m_b1, rx_data}; m_n <= 0; m_pend <= 1'b1;
                end
            end else if (m_n != 0) begin
                if (TMO_EN && m_idle == TC - 1) begin
                    m_n <= 0; m_idle <= 0; m_serr <= 1'b1;
                end else begin
                    m_idle <= m_idle + 1;
                end
            end
        end
    end

    logic [5:0] exp_vec;
    assign exp_vec = {reset && rx_ready && m_n == 0,
                      reset && rx_ready && m_n == 1,
                      reset && rx_ready && m_n == 2,
                      m_pend,
                      m_pend && m_addr == NP - 1,
                      m_serr};

    // Apply one cycle of inputs right after the edge; return mid-cycle.
    task automatic drive(input bit rdy, input logic [7:0] d, input bit rst);
        @(posedge clk);
        #1;
        rx_ready      = rdy;
        rx_data       = d;
        frame_restart = rst;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0; rx_ready = 1'b0; frame_restart = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_ready = 1'b1; rx_data = 8'h5A; frame_restart = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({r0, r1, r2, pixel_valid, frame_done, sync_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {r0, r1, r2, pixel_valid, frame_done, sync_err});
        end
        n_total++;
        if (pixel_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_addr got=%0d want=0", pixel_addr);
        end
        rx_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_single_pixel();
        logic [7:0] b [3];
        logic [2:0] want;
        b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'h56;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) idle(10);
            send(b[i]);
            want = 3'b100 >> i;
            n_total++;
            if ({r0, r1, r2} !== want) begin
                n_bad++;
                $display("FAIL single_strobe byte=%0d got=%b want=%b", i, {r0, r1, r2}, want);
            end
        end
        idle(1);
        n_total++;
        if ({pixel_valid, frame_done, pixel_addr, bank} !== {1'b1, 1'b0, AW'(0), 24'h123456}) begin
            n_bad++;
            $display("FAIL single_commit got pv=%b fd=%b addr=%0d pix=%h want pv=1 fd=0 addr=0 pix=123456",
                     pixel_valid, frame_done, pixel_addr, bank);
        end
        idle(1);
        n_total++;
        if (pixel_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_pulse_width got pv=%b want=0", pixel_valid);
        end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] b [3];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                idle($urandom_range(0, 3));
                b[j] = 8'($urandom);
                send(b[j]);
            end
            idle(1);
            n_total++;
            if ({pixel_valid, frame_done, pixel_addr, bank} !==
                {1'b1, (k % NP) == NP - 1, AW'(k % NP), b[0], b[1], b[2]}) begin
                n_bad++;
                $display("FAIL frame_wrap k=%0d got pv=%b fd=%b addr=%0d pix=%h want pv=1 fd=%b addr=%0d pix=%h",
                         k, pixel_valid, frame_done, pixel_addr, bank,
                         (k % NP) == NP - 1, k % NP, {b[0], b[1], b[2]});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [6];
        for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
        do_reset();
        send(b[0]); send(b[1]); send(b[2]);
        send(b[3]);
        n_total++;
        if ({pixel_valid, pixel_addr, r0, r1, r2} !== {1'b1, AW'(0), 3'b100}) begin
            n_bad++;
            $display("FAIL b2b_commit_r got pv=%b addr=%0d strobes=%b want pv=1 addr=0 strobes=100",
                     pixel_valid, pixel_addr, {r0, r1, r2});
        end
        send(b[4]);
        n_total++;
        if ({r0, r1, r2} !== 3'b010) begin
            n_bad++;
            $display("FAIL b2b_g_after_commit got=%b want=010", {r0, r1, r2});
        end
        send(b[5]);
        idle(1);
        n_total++;
        if ({pixel_valid, pixel_addr, bank} !== {1'b1, AW'(1), b[3], b[4], b[5]}) begin
            n_bad++;
            $display("FAIL b2b_second got pv=%b addr=%0d pix=%h want pv=1 addr=1 pix=%h",
                     pixel_valid, pixel_addr, bank, {b[3], b[4], b[5]});
        end
    endtask

    task automatic test_reset_midpixel();
        do_reset();
        send(8'h01); send(8'h02); send(8'h03);
        idle(2);
        send(8'h11); send(8'h22);
        rx_ready = 1'b1;
        rx_data  = 8'h33;
        reset    = 1'b0;
        #1;
        n_total++;
        if ({r0, r1, r2, pixel_valid, frame_done, sync_err, pixel_addr} !== {6'b0, AW'(0)}) begin
            n_bad++;
            $display("FAIL midpixel_reset got=%b addr=%0d want=000000 addr=0",
                     {r0, r1, r2, pixel_valid, frame_done, sync_err}, pixel_addr);
        end
        rx_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        send(8'hAA); send(8'hBB); send(8'hCC);
        idle(1);
        n_total++;
        if ({pixel_valid, pixel_addr, bank} !== {1'b1, AW'(0), 24'hAABBCC}) begin
            n_bad++;
            $display("FAIL midpixel_after got pv=%b addr=%0d pix=%h want pv=1 addr=0 pix=aabbcc",
                     pixel_valid, pixel_addr, bank);
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
            idle(1);
        end
        send(8'h71); send(8'h72);
        drive(1'b0, 8'h00, 1'b1);
        idle(2);
        send(8'h81);
        n_total++;
        if ({r0, r1, r2} !== 3'b100) begin
            n_bad++;
            $display("FAIL restart_resync got=%b want=100", {r0, r1, r2});
        end
        send(8'h82); send(8'h83);
        idle(1);
        n_total++;
        if ({pixel_valid, pixel_addr, bank} !== {1'b1, AW'(0), 24'h818283}) begin
            n_bad++;
            $display("FAIL restart_addr got pv=%b addr=%0d pix=%h want pv=1 addr=0 pix=818283",
                     pixel_valid, pixel_addr, bank);
        end
        send(8'h91);
        drive(1'b1, 8'h92, 1'b1);
        n_total++;
        if ({r0, r1, r2} !== 3'b010) begin
            n_bad++;
            $display("FAIL restart_strobe got=%b want=010", {r0, r1, r2});
        end
        send(8'h93);
        n_total++;
        if ({r0, r1, r2} !== 3'b100) begin
            n_bad++;
            $display("FAIL restart_no_advance got=%b want=100", {r0, r1, r2});
        end
        idle(TC + 4);
    endtask

    task automatic test_timeout();
`ifdef PIXEL_SEQ_TIMEOUT_EN
        do_reset();
        send(8'h10);
        idle(TC - 1);
        n_total++;
        if (sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_early got=%b want=0", sync_err);
        end
        idle(1);
        idle(1);
        n_total++;
        if (sync_err !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_pulse got=%b want=1", sync_err);
        end
        send(8'h20);
        n_total++;
        if ({r0, r1, r2, sync_err} !== 4'b1000) begin
            n_bad++;
            $display("FAIL tmo_resync got=%b want=1000", {r0, r1, r2, sync_err});
        end
        idle(TC - 1);
        send(8'h30);
        n_total++;
        if ({r0, r1, r2, sync_err} !== 4'b0100) begin
            n_bad++;
            $display("FAIL tmo_byte_wins got=%b want=0100", {r0, r1, r2, sync_err});
        end
        idle(1);
        n_total++;
        if (sync_err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_byte_wins_err got=%b want=0", sync_err);
        end
        send(8'h40);
        idle(1);
        n_total++;
        if ({pixel_valid, bank} !== {1'b1, 24'h203040}) begin
            n_bad++;
            $display("FAIL tmo_pixel got pv=%b pix=%h want pv=1 pix=203040", pixel_valid, bank);
        end
`else
        bit seen;
        do_reset();
        send(8'h10);
        seen = 1'b0;
        for (int i = 0; i < 3 * TC; i++) begin
            drive(1'b0, 8'($urandom), 1'b0);
            seen = seen | sync_err;
        end
        n_total++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL notmo_err got=%b want=0", seen);
        end
        send(8'h20);
        n_total++;
        if ({r0, r1, r2} !== 3'b010) begin
            n_bad++;
            $display("FAIL notmo_wait got=%b want=010", {r0, r1, r2});
        end
        send(8'h30);
        idle(1);
        n_total++;
        if ({pixel_valid, bank} !== {1'b1, 24'h102030}) begin
            n_bad++;
            $display("FAIL notmo_pixel got pv=%b pix=%h want pv=1 pix=102030", pixel_valid, bank);
        end
`endif
    endtask

    task automatic test_random();
        int quiet;
        int r;
        bit rdy, rst;
        quiet = 0;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = 1'b0;
            if (quiet > 0) begin
                rdy = 1'b0;
                quiet--;
            end else begin
                r   = $urandom_range(0, 99);
                rdy = (r < 55);
                rst = (r == 96);
                if (r >= 97) quiet = $urandom_range(10, 20);
            end
            drive(rdy, 8'($urandom), rst);
            n_total++;
            if ({r0, r1, r2, pixel_valid, frame_done, sync_err} !== exp_vec ||
                (m_pend && (pixel_addr !== AW'(m_addr) || bank !== m_pix))) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b addr=%0d pix=%h want=%b addr=%0d pix=%h",
                         i, {r0, r1, r2, pixel_valid, frame_done, sync_err}, pixel_addr, bank,
                         exp_vec, m_addr, m_pix);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_frame_wrap();
        test_back_to_back();
        test_reset_midpixel();
        test_restart();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
